// File: rtl/life_pkg.sv
// Shared definitions for the life array sequencer.
//
// Holds the default array geometry (ROWS), the generation counter width
// (GEN_W) and the sequencer state encoding, so that the sequencer and anything
// that talks to it agree on these.
package life_pkg;

  localparam int ROWS  = 16;
  localparam int GEN_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP,
    DONE
  } state_e;

endpackage

// File: rtl/life_array_sequencer.sv
// Life array sequencer.
//
// Drives an external Game-of-Life cell array through one load-run-dump
// sequence per accepted cmd_start:
//   LOAD : stream ROWS rows from the host into the array (valid/ready).
//   RUN  : pulse arr_step once per requested generation.
//   DUMP : stream every row (current and previous generation) back to the
//          host (valid/ready).
//   DONE : one-cycle completion pulse.
//
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   cmd_start, gen_count      : start request and generation count
//   load_data/valid/ready     : host -> array row stream
//   dump_data/prev/row/valid/ready : array -> host row stream
//   busy, done                : sequence status
//   arr_vali, arr_vali_selector, arr_write_enb : array write port
//   arr_step                  : array generation advance
//   arr_valo_selector, arr_valo, arr_valo_prev : array read port
module life_array_sequencer #(
  parameter int ROWS  = life_pkg::ROWS,
  parameter int GEN_W = life_pkg::GEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic [GEN_W-1:0] gen_count,
  input  logic [15:0]      load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [15:0]      dump_data,
  output logic [15:0]      dump_prev,
  output logic [3:0]       dump_row,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      arr_vali,
  output logic [3:0]       arr_vali_selector,
  output logic             arr_write_enb,
  output logic             arr_step,
  output logic [3:0]       arr_valo_selector,
  input  logic [15:0]      arr_valo,
  input  logic [15:0]      arr_valo_prev
);

  localparam logic [3:0]       LAST_ROW = 4'(ROWS - 1);
  localparam logic [GEN_W-1:0] GEN_ZERO = '0;
  localparam logic [GEN_W-1:0] GEN_ONE  = GEN_W'(1);

  life_pkg::state_e  state;
  logic [3:0]        row_cnt;
  logic [GEN_W-1:0]  gen_cnt;

  // Sequencer state, row counter and remaining-generation counter.
  // In RUN, gen_cnt holds the number of steps still to issue including the
  // current cycle, so the last step is the cycle where it reads one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= life_pkg::IDLE;
      row_cnt <= '0;
      gen_cnt <= '0;
    end else begin
      case (state)
        life_pkg::IDLE: begin
          if (cmd_start) begin
            state   <= life_pkg::LOAD;
            row_cnt <= '0;
            gen_cnt <= gen_count;
          end
        end
        life_pkg::LOAD: begin
          if (load_valid) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt <= '0;
              state   <= (gen_cnt == GEN_ZERO) ? life_pkg::DUMP : life_pkg::RUN;
            end else begin
              row_cnt <= row_cnt + 4'd1;
            end
          end
        end
        life_pkg::RUN: begin
          if (gen_cnt == GEN_ONE) begin
            state   <= life_pkg::DUMP;
            row_cnt <= '0;
            gen_cnt <= '0;
          end else begin
            gen_cnt <= gen_cnt - GEN_ONE;
          end
        end
        life_pkg::DUMP: begin
          if (dump_ready) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt <= '0;
              state   <= life_pkg::DONE;
            end else begin
              row_cnt <= row_cnt + 4'd1;
            end
          end
        end
        life_pkg::DONE: begin
          state <= life_pkg::IDLE;
        end
        default: begin
          state   <= life_pkg::IDLE;
          row_cnt <= '0;
          gen_cnt <= '0;
        end
      endcase
    end
  end

  // Port outputs decode from the registered state and row counter; the
  // array and host handshakes pass straight through so rows move at one per
  // cycle without an extra pipeline stage.
  always_comb begin
    load_ready        = 1'b0;
    arr_write_enb     = 1'b0;
    arr_vali          = '0;
    arr_vali_selector = '0;
    arr_step          = 1'b0;
    dump_valid        = 1'b0;
    dump_row          = '0;
    dump_data         = '0;
    dump_prev         = '0;
    arr_valo_selector = '0;
    busy              = (state != life_pkg::IDLE);
    done              = (state == life_pkg::DONE);
    case (state)
      life_pkg::LOAD: begin
        load_ready        = 1'b1;
        arr_write_enb     = load_valid;
        arr_vali          = load_data;
        arr_vali_selector = row_cnt;
      end
      life_pkg::RUN: begin
        arr_step = 1'b1;
      end
      life_pkg::DUMP: begin
        dump_valid        = 1'b1;
        dump_row          = row_cnt;
        arr_valo_selector = row_cnt;
        dump_data         = arr_valo;
        dump_prev         = arr_valo_prev;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_life_array_sequencer.sv
// Testbench for life_array_sequencer.
//
// A behavioural cell array answers the sequencer's array port. Expected dump
// rows come from applying the Game-of-Life rule directly to the loaded grid
// the requested number of times (cells outside the 16x16 grid are dead).
module tb_life_array_sequencer;

  typedef logic [15:0] grid_t [16];

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [7:0]  gen_count;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] dump_data;
  logic [15:0] dump_prev;
  logic [3:0]  dump_row;
  logic        dump_valid;
  logic        dump_ready;
  logic        busy;
  logic        done;
  logic [15:0] arr_vali;
  logic [3:0]  arr_vali_selector;
  logic        arr_write_enb;
  logic        arr_step;
  logic [3:0]  arr_valo_selector;
  logic [15:0] arr_valo;
  logic [15:0] arr_valo_prev;

  int checks = 0;
  int fails  = 0;

  grid_t mem_cur  = '{default: '0};
  grid_t mem_prev = '{default: '0};
  grid_t got_data;
  grid_t got_prev;

  life_array_sequencer #(.ROWS(16), .GEN_W(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_start         (cmd_start),
    .gen_count         (gen_count),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .dump_data         (dump_data),
    .dump_prev         (dump_prev),
    .dump_row          (dump_row),
    .dump_valid        (dump_valid),
    .dump_ready        (dump_ready),
    .busy              (busy),
    .done              (done),
    .arr_vali          (arr_vali),
    .arr_vali_selector (arr_vali_selector),
    .arr_write_enb     (arr_write_enb),
    .arr_step          (arr_step),
    .arr_valo_selector (arr_valo_selector),
    .arr_valo          (arr_valo),
    .arr_valo_prev     (arr_valo_prev)
  );

  always #5 clk = ~clk;

  // One Game-of-Life generation on a bounded 16x16 grid.
  function automatic grid_t lifeNext(input grid_t g);
    grid_t n;
    int cnt;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 16 &&
                (c + dc) >= 0 && (c + dc) < 16) begin
              if (g[r + dr][c + dc]) cnt++;
            end
          end
        end
        n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Behavioural cell array: writes land in the current grid, a step moves the
  // whole grid forward one generation and keeps the old one as previous.
  always @(posedge clk) begin
    if (arr_write_enb) begin
      mem_cur[arr_vali_selector] <= arr_vali;
    end else if (arr_step) begin
      mem_prev <= mem_cur;
      mem_cur  <= lifeNext(mem_cur);
    end
  end

  assign arr_valo      = mem_cur[arr_valo_selector];
  assign arr_valo_prev = mem_prev[arr_valo_selector];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one full load-run-dump sequence with the given grid and generation
  // count. gap: random load_valid gaps; toggle: dump_ready alternates each
  // cycle; rnd: random dump_ready; pulse: extra cmd_start pulses while busy.
  task automatic applyStimulus(input grid_t rows, input int gen, input bit gap,
                               input bit toggle, input bit rnd, input bit pulse);
    grid_t exp_cur;
    grid_t exp_prev;
    int load_idx = 0;
    int dump_idx = 0;
    int writes = 0;
    int steps = 0;
    int dones = 0;
    int cyc = 0;
    bit finished = 0;
    bit first = 1;
    bit last_stall = 0;
    bit last_load = 0;
    bit last_dump = 0;
    logic [3:0]  held_row = '0;
    logic [15:0] held_data = '0;
    logic [15:0] held_prev = '0;

    exp_cur  = rows;
    exp_prev = rows;
    for (int i = 0; i < gen; i++) begin
      exp_prev = exp_cur;
      exp_cur  = lifeNext(exp_cur);
    end

    @(posedge clk);
    #1;
    gen_count = 8'(gen);
    cmd_start = 1'b1;
    @(negedge clk);
    checkOutput("busy_before_start", 32'(busy), 32'd0);
    @(posedge clk);
    while (!finished && cyc < 3000) begin
      #1;
      cyc++;
      cmd_start  = pulse && (last_load || last_dump) && ($urandom_range(0, 2) == 0);
      gen_count  = 8'($urandom_range(0, 255));
      load_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data  = (load_idx < 16) ? rows[load_idx] : 16'($urandom);
      if (toggle)   dump_ready = cyc[0];
      else if (rnd) dump_ready = ($urandom_range(0, 1) == 1);
      else          dump_ready = 1'b1;
      @(negedge clk);
      if (first) checkOutput("busy_after_start", 32'(busy), 32'd1);
      first = 0;
      if (last_stall) begin
        checkOutput("stall_valid", 32'(dump_valid), 32'd1);
        checkOutput("stall_row", 32'(dump_row), 32'(held_row));
        checkOutput("stall_data", 32'(dump_data), 32'(held_data));
        checkOutput("stall_prev", 32'(dump_prev), 32'(held_prev));
      end
      if (arr_write_enb) writes++;
      if (arr_step) steps++;
      if (load_ready) checkOutput("load_wen", 32'(arr_write_enb), 32'(load_valid));
      if (load_valid && load_ready && load_idx < 16) begin
        checkOutput("load_sel", 32'(arr_vali_selector), 32'(load_idx));
        checkOutput("load_data", 32'(arr_vali), 32'(rows[load_idx]));
        load_idx++;
      end
      if (dump_valid && dump_ready && dump_idx < 16) begin
        checkOutput("dump_row", 32'(dump_row), 32'(dump_idx));
        checkOutput("dump_data", 32'(dump_data), 32'(exp_cur[dump_idx]));
        if (gen > 0) checkOutput("dump_prev", 32'(dump_prev), 32'(exp_prev[dump_idx]));
        got_data[dump_idx] = dump_data;
        got_prev[dump_idx] = dump_prev;
        dump_idx++;
      end
      if (done) begin
        dones++;
        checkOutput("done_busy", 32'(busy), 32'd1);
        finished = 1;
      end
      last_stall = dump_valid && !dump_ready;
      last_load  = load_ready;
      last_dump  = dump_valid;
      held_row   = dump_row;
      held_data  = dump_data;
      held_prev  = dump_prev;
      if (!finished) @(posedge clk);
    end
    if (!finished) checkOutput("timeout", 32'd0, 32'd1);

    #1;
    cmd_start  = 1'b0;
    load_valid = 1'b0;
    dump_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (busy || done) dones += 16;
    end
    checkOutput("load_count", 32'(load_idx), 32'd16);
    checkOutput("write_count", 32'(writes), 32'd16);
    checkOutput("step_count", 32'(steps), 32'(gen));
    checkOutput("dump_count", 32'(dump_idx), 32'd16);
    checkOutput("done_count", 32'(dones), 32'd1);
  endtask

  grid_t pattern;

  initial begin
    int steps;
    int idx;
    int cyc;

    reset      = 1'b1;
    cmd_start  = 1'b0;
    gen_count  = '0;
    load_data  = '0;
    load_valid = 1'b0;
    dump_ready = 1'b0;

    // Outputs held at zero while reset is applied, even with stimulus present.
    @(posedge clk);
    #1;
    cmd_start  = 1'b1;
    load_valid = 1'b1;
    dump_ready = 1'b1;
    load_data  = 16'hFFFF;
    @(negedge clk);
    checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
    checkOutput("rst_dump_valid", 32'(dump_valid), 32'd0);
    checkOutput("rst_dump_row", 32'(dump_row), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wen", 32'(arr_write_enb), 32'd0);
    checkOutput("rst_step", 32'(arr_step), 32'd0);
    checkOutput("rst_vali", 32'(arr_vali), 32'd0);
    checkOutput("rst_vali_sel", 32'(arr_vali_selector), 32'd0);
    checkOutput("rst_valo_sel", 32'(arr_valo_selector), 32'd0);
    @(posedge clk);
    #1;
    cmd_start  = 1'b0;
    load_valid = 1'b0;
    dump_ready = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy_post_rst", 32'(busy), 32'd0);

    // Blinker: one generation turns the horizontal bar vertical.
    pattern = '{default: '0};
    pattern[7] = 16'h0380;
    applyStimulus(pattern, 1, 0, 0, 0, 0);
    checkOutput("blink_row6", 32'(got_data[6]), 32'h0100);
    checkOutput("blink_row7", 32'(got_data[7]), 32'h0100);
    checkOutput("blink_row8", 32'(got_data[8]), 32'h0100);
    checkOutput("blink_row5", 32'(got_data[5]), 32'h0000);
    checkOutput("blink_prev7", 32'(got_prev[7]), 32'h0380);

    // Zero generations: the loaded grid comes straight back in row order.
    for (int r = 0; r < 16; r++) pattern[r] = 16'h1 << r;
    applyStimulus(pattern, 0, 0, 0, 0, 0);
    checkOutput("diag_row0", 32'(got_data[0]), 32'h0001);
    checkOutput("diag_row15", 32'(got_data[15]), 32'h8000);

    // Backpressure: gapped loads and alternating dump_ready.
    for (int r = 0; r < 16; r++) pattern[r] = 16'($urandom) & 16'($urandom);
    applyStimulus(pattern, 3, 1, 1, 0, 0);

    // Extra cmd_start pulses during LOAD and DUMP must be ignored.
    for (int r = 0; r < 16; r++) pattern[r] = 16'($urandom);
    applyStimulus(pattern, 2, 1, 0, 1, 1);

    // Reset on the third RUN cycle of a ten-generation run.
    for (int r = 0; r < 16; r++) pattern[r] = 16'($urandom);
    @(posedge clk);
    #1;
    gen_count = 8'd10;
    cmd_start = 1'b1;
    @(posedge clk);
    #1;
    cmd_start  = 1'b0;
    load_valid = 1'b1;
    steps = 0;
    idx   = 0;
    cyc   = 0;
    while (steps < 3 && cyc < 200) begin
      cyc++;
      load_data = (idx < 16) ? pattern[idx] : 16'h0;
      @(negedge clk);
      if (load_valid && load_ready) idx++;
      if (arr_step) steps++;
      if (steps < 3) begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("midrun_reached", 32'(steps), 32'd3);
    reset = 1'b1;
    load_valid = 1'b0;
    #1;
    checkOutput("midrun_rst_busy", 32'(busy), 32'd0);
    checkOutput("midrun_rst_step", 32'(arr_step), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrun_next_busy", 32'(busy), 32'd0);
    checkOutput("midrun_next_step", 32'(arr_step), 32'd0);
    checkOutput("midrun_next_ready", 32'(load_ready), 32'd0);
    checkOutput("midrun_next_dvalid", 32'(dump_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrun_idle_busy", 32'(busy), 32'd0);

    // A fresh sequence after the abort, then a few random ones.
    applyStimulus(pattern, 4, 0, 0, 0, 0);
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < 16; r++) pattern[r] = 16'($urandom) & 16'($urandom);
      applyStimulus(pattern, $urandom_range(0, 5), ($urandom_range(0, 1) == 1),
                    0, 1, ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
